// File: rtl/acc_rr_sched.sv
// Round-robin scheduler sharing one guarded accumulator among N requesters.
// Optional guard feature: define ACC_RR_SCHED_GUARD_EN to enable the (op == acc) update guard.
module acc_rr_sched #(
  parameter int W      = 2,
  parameter int N      = 2,
  parameter int INIT   = 1,
  parameter int TARGET = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] add,
  output logic [N-1:0]   gnt,
  output logic           done,
  output logic           accept,
  output logic [W-1:0]   acc,
  output logic           hit,
  output logic           wrap,
  output logic           busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] INIT_W   = W'(INIT);
  localparam logic [W-1:0] TARGET_W = W'(TARGET);

  typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

  state_t         r_state;
  logic [W-1:0]   r_acc;
  logic [W-1:0]   r_op;
  logic [PW-1:0]  r_ptr;
  logic [PW-1:0]  r_win;
  logic [N-1:0]   r_gnt;
  logic           r_done;
  logic           r_accept;
  logic           r_wrap;

  logic           w_found;
  logic [PW-1:0]  w_idx;
  logic [W-1:0]   w_op;
  logic [W:0]     w_sum;
  logic           w_g;
  logic [PW-1:0]  w_ptr_next;

  // First set request at or above ptr, wrapping modulo N.
  always_comb begin
    int unsigned j;
    j       = 0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = 32'(r_ptr) + k;
      if (j >= N) j = j - N;
      if (!w_found && req[j]) begin
        w_found = 1'b1;
        w_idx   = PW'(j);
      end
    end
  end

  assign w_op  = add[int'(w_idx)*W +: W];
  assign w_sum = {1'b0, r_acc} + {1'b0, r_op};

`ifdef ACC_RR_SCHED_GUARD_EN
  assign w_g = (r_op == r_acc);
`else
  assign w_g = 1'b1;
`endif

  assign w_ptr_next = (r_win == PW'(N-1)) ? '0 : r_win + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_acc    <= INIT_W;
      r_op     <= '0;
      r_ptr    <= '0;
      r_win    <= '0;
      r_gnt    <= '0;
      r_done   <= 1'b0;
      r_accept <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_win   <= w_idx;
            r_op    <= w_op;
            r_gnt   <= N'(1) << w_idx;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          if (w_g) begin
            r_acc  <= w_sum[W-1:0];
            r_wrap <= r_wrap | w_sum[W];
          end
          r_accept <= w_g;
          r_done   <= 1'b1;
          r_ptr    <= w_ptr_next;
          r_state  <= DONE;
        end
        DONE: begin
          r_gnt    <= '0;
          r_done   <= 1'b0;
          r_accept <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt    = r_gnt;
  assign done   = r_done;
  assign accept = r_accept;
  assign acc    = r_acc;
  assign hit    = (r_acc == TARGET_W);
  assign wrap   = r_wrap;
  assign busy   = (r_state != IDLE);

endmodule
